// File: rtl/cu_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cu_sched : two-requester round-robin scheduler and CU power-mode controller
// Rev 1.0
// ---------------------------------------------------------------------------
package ptype_pkg;
   typedef enum logic {ADD = 1'b0, MUL = 1'b1} operation_t;
   typedef enum logic {LP = 1'b0, NORMAL = 1'b1} powermode_t;
   typedef logic [3:0] flags_t;
endpackage

module cu_sched
   import ptype_pkg::*;
#(
   parameter int W            = 16,
   parameter int ADD_LAT      = 1,
   parameter int MUL_LAT      = 3,
   parameter int WAKE_CYC     = 2,
   parameter int IDLE_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [W-1:0]     req_op1 [0:1],
   input  logic [W-1:0]     req_op2 [0:1],
   input  operation_t       req_op  [0:1],
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [W-1:0]     rsp_result,
   output flags_t           rsp_fls,
   output logic [W-1:0]     cu_op1,
   output logic [W-1:0]     cu_op2,
   output operation_t       cu_op,
   output powermode_t       cu_pmode,
   input  logic [W-1:0]     cu_result,
   input  flags_t           cu_fls
);

   localparam int c_lat_max  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
   localparam int c_tim_max  = (WAKE_CYC > IDLE_TIMEOUT) ? WAKE_CYC : IDLE_TIMEOUT;
   localparam int c_cnt_max  = (c_lat_max > c_tim_max) ? c_lat_max : c_tim_max;
   localparam int c_cw       = $clog2(c_cnt_max + 1);

   localparam logic [c_cw-1:0] c_wake_end = c_cw'(WAKE_CYC - 1);
   localparam logic [c_cw-1:0] c_idle_end = c_cw'(IDLE_TIMEOUT - 1);
   localparam logic [c_cw-1:0] c_add_end  = c_cw'(ADD_LAT - 1);
   localparam logic [c_cw-1:0] c_mul_end  = c_cw'(MUL_LAT - 1);

   typedef enum logic [2:0] {
      S_SLEEP = 3'd0,
      S_WAKE  = 3'd1,
      S_IDLE  = 3'd2,
      S_BUSY  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [c_cw-1:0]   cnt_q, cnt_d;
   logic              last_gnt_q, last_gnt_d;
   logic [W-1:0]      op1_q, op1_d, op2_q, op2_d;
   operation_t        op_q, op_d;
   logic              id_q, id_d;
   logic [W-1:0]      rsp_result_q, rsp_result_d;
   flags_t            rsp_fls_q, rsp_fls_d;
   logic              rsp_id_q, rsp_id_d;

   logic              w_any;
   logic              w_win;
   logic [c_cw-1:0]   w_lat_end;

   // On a tie the requester that was not served last wins.
   assign w_any     = |req_valid;
   assign w_win     = (req_valid == 2'b11) ? ~last_gnt_q : req_valid[1];
   assign w_lat_end = (op_q == MUL) ? c_mul_end : c_add_end;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_gnt_d   = last_gnt_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      op_d         = op_q;
      id_d         = id_q;
      rsp_result_d = rsp_result_q;
      rsp_fls_d    = rsp_fls_q;
      rsp_id_d     = rsp_id_q;
      req_ready    = 2'b00;
      rsp_valid    = 1'b0;
      cu_pmode     = NORMAL;
      case (state_q)
         S_SLEEP: begin
            cu_pmode = LP;
            if (w_any) begin
               state_d = S_WAKE;
               cnt_d   = '0;
            end
         end
         S_WAKE: begin
            if (cnt_q == c_wake_end) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            // Ready is only offered to a valid requester, so any valid is a handshake.
            if (w_any) begin
               req_ready[w_win] = 1'b1;
               op1_d      = req_op1[w_win];
               op2_d      = req_op2[w_win];
               op_d       = req_op[w_win];
               id_d       = w_win;
               last_gnt_d = w_win;
               state_d    = S_BUSY;
               cnt_d      = '0;
            end else if (cnt_q == c_idle_end) begin
               state_d = S_SLEEP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BUSY: begin
            if (cnt_q == w_lat_end) begin
               rsp_result_d = cu_result;
               rsp_fls_d    = cu_fls;
               rsp_id_d     = id_q;
               state_d      = S_RESP;
               cnt_d        = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_SLEEP;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_SLEEP;
         cnt_q        <= '0;
         last_gnt_q   <= 1'b1;
         op1_q        <= '0;
         op2_q        <= '0;
         op_q         <= ADD;
         id_q         <= 1'b0;
         rsp_result_q <= '0;
         rsp_fls_q    <= '0;
         rsp_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_gnt_q   <= last_gnt_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         op_q         <= op_d;
         id_q         <= id_d;
         rsp_result_q <= rsp_result_d;
         rsp_fls_q    <= rsp_fls_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   // Operand registers change only at a handshake, so they hold through BUSY and after.
   assign cu_op1     = op1_q;
   assign cu_op2     = op2_q;
   assign cu_op      = op_q;
   assign rsp_result = rsp_result_q;
   assign rsp_fls    = rsp_fls_q;
   assign rsp_id     = rsp_id_q;

endmodule
`default_nettype wire
